conv_out_packer: RTL and testbench

Receiving end of the convolution kernel's output stream. Collects the per-pixel activation values (`ACT_BITS` each, qualified by a valid strobe, no back-pressure) and packs `PACK` consecutive values into one output-buffer word. Writes the words to the output SRAM through a valid/ready write port with an auto-incrementing address. A small word FIFO absorbs write-port stalls; overflow is flagged, never silently hidden.

---
 rtl/conv_out_packer_if.sv | 26 ++
 rtl/conv_out_packer.sv | 162 ++++++++++++++++
 tb/tb_conv_out_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_out_packer_if.sv
// Output-buffer write port of the convolution output packer.
// The packer drives the write request; the buffer answers with ready.
interface conv_out_packer_if #(
    parameter int ACT_BITS  = 8,
    parameter int PACK      = 16,
    parameter int ADDR_BITS = 12
) ();
    logic                     wr_en;
    logic [ADDR_BITS-1:0]     wr_addr;
    logic [PACK*ACT_BITS-1:0] wr_data;
    logic                     wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/conv_out_packer.sv
// Packs PACK consecutive activation values into one output-buffer word and
// writes the words through a small FIFO to the output SRAM, with an
// auto-incrementing address. Dropped or excess data raises a sticky ovf.
module conv_out_packer #(
    parameter int ACT_BITS   = 8,
    parameter int PACK       = 16,
    parameter int ADDR_BITS  = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] num_words,
    input  logic [ACT_BITS-1:0]  acc_i,
    input  logic                 vld_i,
    conv_out_packer_if.master    wr,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = PACK * ACT_BITS;

    // DONE is the single cycle after the last transfer: done and busy are
    // both high there, and a new start is still refused.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic                         ovf_q, ovf_d;
    logic                         zdone_q, zdone_d;
    logic [ADDR_BITS-1:0]         base_q, nwords_q, packed_q, written_q;
    logic [LW-1:0]                lane_q;
    logic [PACK-1:0][ACT_BITS-1:0] asm_q;
    logic [WW-1:0]                push_word;
    logic [WW-1:0]                mem_q [FIFO_DEPTH];
    logic [PW-1:0]                wptr_q, rptr_q;
    logic [CW-1:0]                cnt_q;

    logic accept, take, excess, lane_last;
    logic push, push_ok, pop, full, drop, last_xfer;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept    = (state_q == IDLE) && start;
    assign take      = (state_q == RUN) && vld_i && (packed_q != nwords_q);
    assign excess    = (state_q == RUN) && vld_i && (packed_q == nwords_q);
    assign lane_last = (lane_q == LW'(PACK - 1));
    assign push      = take && lane_last;
    assign pop       = (cnt_q != '0) && wr.wr_ready;
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign drop      = push && full && !pop;
    assign push_ok   = push && !drop;
    assign last_xfer = (state_q == RUN) && pop && (written_q == nwords_q - ADDR_BITS'(1));

    // Completed word: the assembly register with the final lane taken
    // straight from the input, so it is pushed on the same edge.
    always_comb begin
        logic [PACK-1:0][ACT_BITS-1:0] w;
        w             = asm_q;
        w[PACK-1]     = acc_i;
        push_word     = w;
    end

    // Frame state register with sticky overflow and zero-length done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            zdone_q <= zdone_d;
        end
    end

    // Next-state logic: frame start/end and overflow detection.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        zdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (num_words == '0) zdone_d = 1'b1;
                    else                 state_d = RUN;
                end
            end
            RUN: begin
                if (last_xfer)      state_d = DONE;
                if (excess || drop) ovf_d   = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame parameters, lane assembly and the packed/written word counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q    <= '0;
            nwords_q  <= '0;
            packed_q  <= '0;
            written_q <= '0;
            lane_q    <= '0;
            asm_q     <= '0;
        end else if (accept) begin
            base_q    <= base_addr;
            nwords_q  <= num_words;
            packed_q  <= '0;
            written_q <= '0;
            lane_q    <= '0;
        end else begin
            if (take) begin
                asm_q[lane_q] <= acc_i;
                lane_q        <= lane_last ? '0 : lane_q + 1'b1;
                if (lane_last) packed_q <= packed_q + 1'b1;
            end
            if (pop) written_q <= written_q + 1'b1;
        end
    end

    // Word FIFO between the packer and the write port; a push and a pop on
    // the same edge are both honoured even when full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= push_word;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign wr.wr_en   = (cnt_q != '0);
    assign wr.wr_addr = base_q + written_q;
    assign wr.wr_data = mem_q[rptr_q];

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE) || zdone_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_conv_out_packer.sv
// Directed testbench for conv_out_packer.
module tb_conv_out_packer;
    localparam int ACT_BITS   = 8;
    localparam int PACK       = 16;
    localparam int ADDR_BITS  = 12;
    localparam int FIFO_DEPTH = 2;
    localparam int WW         = PACK * ACT_BITS;

    logic                 clk = 1'b0;
    logic                 rstn, start, vld_i, busy, done, ovf;
    logic [ADDR_BITS-1:0] base_addr, num_words;
    logic [ACT_BITS-1:0]  acc_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_xfer = 0;
    logic [ADDR_BITS-1:0] wa[$];
    logic [WW-1:0]        wd[$];

    conv_out_packer_if #(.ACT_BITS(ACT_BITS), .PACK(PACK), .ADDR_BITS(ADDR_BITS)) wr_if ();

    conv_out_packer #(
        .ACT_BITS(ACT_BITS), .PACK(PACK), .ADDR_BITS(ADDR_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .num_words(num_words), .acc_i(acc_i), .vld_i(vld_i), .wr(wr_if),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled half a cycle before the edge.
    always @(negedge clk) begin
        if (wr_if.wr_en && wr_if.wr_ready) begin
            wa.push_back(wr_if.wr_addr);
            wd.push_back(wr_if.wr_data);
            last_xfer <= cyc + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [WW-1:0] exp_word(input int first);
        logic [WW-1:0] w;
        for (int i = 0; i < PACK; i++) w[i*ACT_BITS +: ACT_BITS] = ACT_BITS'(first + i);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            acc_i = ACT_BITS'(first + i);
            vld_i = 1'b1;
            tick();
        end
        vld_i = 1'b0;
    endtask

    task automatic do_start(input int b, input int n);
        start     = 1'b1;
        base_addr = ADDR_BITS'(b);
        num_words = ADDR_BITS'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit seen, output int dcyc);
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        rstn  = 1'b0;
        start = 1'b0;
        vld_i = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; vld_i = 1'b0; acc_i = '0;
        base_addr = '0; num_words = '0; wr_if.wr_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, ovf, wr_if.wr_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, ovf, wr_if.wr_en});
        end
        checks++;
        if (wr_if.wr_addr !== '0) begin
            errors++; $display("FAIL reset_addr: got %h expected 000", wr_if.wr_addr);
        end
        checks++;
        if (wr_if.wr_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", wr_if.wr_data);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n0, dcyc;
        bit seen;
        n0 = wa.size();
        wr_if.wr_ready = 1'b1;
        do_start(12'h010, 2);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy_after_start: got %b expected 1", busy);
        end
        send(0, 32);
        wait_done(40, seen, dcyc);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_done_seen: got 0 expected 1"); end
        checks++;
        if (wa.size() - n0 != 2) begin
            errors++; $display("FAIL basic_nwrites: got %0d expected 2", wa.size() - n0);
        end
        checks++;
        if (wa[n0] !== 12'h010 || wd[n0] !== exp_word(0)) begin
            errors++; $display("FAIL basic_word0: got %h/%h expected 010/%h", wa[n0], wd[n0], exp_word(0));
        end
        checks++;
        if (wa[n0+1] !== 12'h011 || wd[n0+1] !== exp_word(16)) begin
            errors++; $display("FAIL basic_word1: got %h/%h expected 011/%h", wa[n0+1], wd[n0+1], exp_word(16));
        end
        checks++;
        if (dcyc != last_xfer) begin
            errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", dcyc, last_xfer);
        end
        checks++;
        if ({busy, ovf} !== 2'b10) begin
            errors++; $display("FAIL basic_busy_ovf_at_done: got %b expected 10", {busy, ovf});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL basic_after_done: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_stall();
        int n0, dcyc, k;
        bit seen, stable;
        logic [WW-1:0]        hd;
        logic [ADDR_BITS-1:0] ha;
        n0 = wa.size();
        k = 0;
        stable = 1'b1;
        wr_if.wr_ready = 1'b0;
        do_start(12'h100, 4);
        fork
            send(0, 64);
            begin
                while (!wr_if.wr_en && k < 100) begin tick(); k++; end
                hd = wr_if.wr_data;
                ha = wr_if.wr_addr;
                for (int i = 0; i < 20; i++) begin
                    if (!wr_if.wr_en || wr_if.wr_data !== hd || wr_if.wr_addr !== ha) stable = 1'b0;
                    tick();
                end
                wr_if.wr_ready = 1'b1;
            end
        join
        checks++;
        if (k >= 100) begin errors++; $display("FAIL stall_wr_en_seen: got 0 expected 1"); end
        checks++;
        if (!stable || hd !== exp_word(0) || ha !== 12'h100) begin
            errors++; $display("FAIL stall_hold: got stable=%0d addr=%h expected stable=1 addr=100", stable, ha);
        end
        wait_done(60, seen, dcyc);
        checks++;
        if (!seen || wa.size() - n0 != 4) begin
            errors++; $display("FAIL stall_nwrites: got %0d done=%0d expected 4 done=1", wa.size() - n0, seen);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa[n0+i] !== ADDR_BITS'(12'h100 + i) || wd[n0+i] !== exp_word(16 * i)) begin
                errors++; $display("FAIL stall_word%0d: got %h/%h expected %h/%h",
                                   i, wa[n0+i], wd[n0+i], 12'h100 + i, exp_word(16 * i));
            end
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL stall_ovf: got %b expected 0", ovf); end
        tick();
    endtask

    task automatic test_overflow();
        int n0, d0;
        n0 = wa.size();
        d0 = done_cnt;
        wr_if.wr_ready = 1'b0;
        do_start(12'h020, 3);
        send(0, 47);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_third_push: got %b expected 0", ovf); end
        send(47, 1);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_third_push: got %b expected 1", ovf); end
        wr_if.wr_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (wa.size() - n0 != 2) begin
            errors++; $display("FAIL ovf_nwrites: got %0d expected 2", wa.size() - n0);
        end
        checks++;
        if (wa[n0] !== 12'h020 || wd[n0] !== exp_word(0) || wa[n0+1] !== 12'h021 || wd[n0+1] !== exp_word(16)) begin
            errors++; $display("FAIL ovf_words: got %h,%h expected 020,021 with words 0 and 1", wa[n0], wa[n0+1]);
        end
        checks++;
        if (done_cnt != d0 || busy !== 1'b1 || wr_if.wr_en !== 1'b0) begin
            errors++; $display("FAIL ovf_stuck: got done_cnt=%0d busy=%b wr_en=%b expected %0d/1/0",
                               done_cnt - d0, busy, wr_if.wr_en, 0);
        end
        apply_reset();
    endtask

    task automatic test_excess_idle();
        int n0, n1, d0, dcyc;
        bit seen;
        n0 = wa.size();
        wr_if.wr_ready = 1'b1;
        do_start(12'h040, 1);
        send(0, 16);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL excess_ovf_16: got %b expected 0", ovf); end
        send(8'h99, 1);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL excess_ovf_17: got %b expected 1", ovf); end
        wait_done(10, seen, dcyc);
        tick();
        checks++;
        if (!seen || wa.size() - n0 != 1 || wa[n0] !== 12'h040 || wd[n0] !== exp_word(0)) begin
            errors++; $display("FAIL excess_write: got n=%0d addr=%h done=%0d expected n=1 addr=040 done=1",
                               wa.size() - n0, wa[n0], seen);
        end
        n1 = wa.size();
        d0 = done_cnt;
        send(8'h55, 4);
        tick();
        checks++;
        if ({busy, ovf, wr_if.wr_en} !== 3'b010 || wr_if.wr_addr !== 12'h041) begin
            errors++; $display("FAIL idle_vld_state: got bov=%b addr=%h expected 010 addr=041",
                               {busy, ovf, wr_if.wr_en}, wr_if.wr_addr);
        end
        checks++;
        if (wa.size() != n1 || done_cnt != d0) begin
            errors++; $display("FAIL idle_vld_activity: got writes=%0d dones=%0d expected 0/0",
                               wa.size() - n1, done_cnt - d0);
        end
    endtask

    task automatic test_wrap_zero();
        int n0, dcyc;
        bit seen;
        n0 = wa.size();
        wr_if.wr_ready = 1'b1;
        do_start(12'hFFF, 2);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL start_clears_ovf: got %b expected 0", ovf); end
        send(8'h80, 32);
        wait_done(40, seen, dcyc);
        tick();
        checks++;
        if (!seen || wa.size() - n0 != 2) begin
            errors++; $display("FAIL wrap_nwrites: got %0d done=%0d expected 2 done=1", wa.size() - n0, seen);
        end
        checks++;
        if (wa[n0] !== 12'hFFF || wd[n0] !== exp_word(8'h80)) begin
            errors++; $display("FAIL wrap_word0: got %h expected FFF", wa[n0]);
        end
        checks++;
        if (wa[n0+1] !== 12'h000 || wd[n0+1] !== exp_word(8'h90)) begin
            errors++; $display("FAIL wrap_word1: got %h expected 000", wa[n0+1]);
        end
        n0 = wa.size();
        do_start(12'h123, 0);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL zero_len_done: got done,busy=%b expected 10", {done, busy});
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00 || wa.size() != n0) begin
            errors++; $display("FAIL zero_len_after: got done,busy=%b writes=%0d expected 00/0",
                               {done, busy}, wa.size() - n0);
        end
    endtask

    task automatic test_reset_midframe();
        int n0, dcyc;
        bit seen;
        wr_if.wr_ready = 1'b1;
        do_start(12'h050, 2);
        send(0, 20);
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, wr_if.wr_en} !== 4'b0000 || wr_if.wr_addr !== '0 || wr_if.wr_data !== '0) begin
            errors++; $display("FAIL midreset_outputs: got ctrl=%b addr=%h expected 0000 addr=000",
                               {busy, done, ovf, wr_if.wr_en}, wr_if.wr_addr);
        end
        tick();
        rstn = 1'b1;
        tick();
        n0 = wa.size();
        do_start(12'h060, 1);
        send(8'hA0, 16);
        wait_done(10, seen, dcyc);
        tick();
        checks++;
        if (!seen || wa.size() - n0 != 1 || wa[n0] !== 12'h060 || wd[n0] !== exp_word(8'hA0)) begin
            errors++; $display("FAIL midreset_new_frame: got n=%0d addr=%h data=%h expected 1/060/%h",
                               wa.size() - n0, wa[n0], wd[n0], exp_word(8'hA0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_excess_idle();
        test_wrap_zero();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
